harmonic_scheduler: RTL and testbench
=====================================

Name: harmonic_scheduler

Overview:
- Shares one quarter-wave sine ROM across three harmonic phase accumulators (1x, 2x, 3x fundamental step).
- Sequences the ROM reads and mixes the three lookups with a selectable weight.
- Emits one signed sample per accepted request.
- Sits between the note player, which supplies step_size, weight, play_enable, note_done and generate_next_sample, and the shared sine ROM. It replaces three parallel sine readers.

Parameters:
PHASE_W, 20, phase accumulator and step width
ROM_AW, 10, sine ROM address width (phase bits [17:8])
SAMPLE_W, 16, signed sample width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
play_enable  in  1  requests are accepted only when 1
generate_next_sample  in  1  one-cycle sample request pulse
step_size  in  20  fundamental phase increment
weight  in  2  mix select: 0 = h1 only; 1 = two-harmonic mix; 2 or 3 = three-harmonic mix
note_done  in  1  blocks requests; clears phases when IDLE
rom_addr  out  10  address to the shared sine ROM
rom_data  in  16  ROM quarter-wave magnitude (0..32767), valid 1 cycle after rom_addr
harmonic_out  out  16  signed mixed sample, held between updates
sample_ready  out  1  one-cycle pulse when harmonic_out updates
busy  out  1  high while in any state other than IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all three phases = 0; harmonic_out = 0; sample_ready = 0; rom_addr = 0; busy = 0.
  - Asserting reset mid-sequence aborts the sequence immediately; no sample_ready is produced.
- Request accept:
  - A request is accepted in IDLE only, when generate_next_sample && play_enable && !note_done.
  - A request in any other state is ignored; it is not queued.
  - A request that is gated off produces no sample_ready, and harmonic_out holds its value.
- Operand latch: on accept, latch step1 = step_size, step2 = step_size<<1, step3 = step_size + (step_size<<1), and weight. All are truncated to 20 bits.
- FSM: IDLE -> RD1 -> RD2 -> RD3 -> CAP3 -> OUT -> IDLE, one cycle per state.
  - RD1: drive rom_addr from phase1.
  - RD2: drive addr from phase2; capture h1.
  - RD3: drive addr from phase3; capture h2.
  - CAP3: capture h3.
  - OUT: register the mix into harmonic_out, pulse sample_ready, and advance phase_i += step_i (mod 2^20).
- Latency: request accepted at cycle 0; sample_ready is high at cycle 5 (in OUT). The next request can be accepted at cycle 6.
- Phase usage: each lookup uses the current phase, then the phase advances. The first sample after reset or a clear is therefore sin(0) = 0.
- Quadrant fold: q = phase[19:18], a = phase[17:8].
  - Address: rom_addr = a for q=0 or 2; rom_addr = 1023-a for q=1 or 3.
  - Sign: the sample is rom_data for q=0 or 1 and -rom_data for q=2 or 3.
  - The sign and fold for each lookup are registered alongside its address.
- Mix, using arithmetic right shifts of the signed 16-bit h values, summed at 18 bits:
  - w0 = h1.
  - w1 = (h1>>>1)+(h1>>>3)+(h2>>>2)+(h2>>>3).
  - w2/w3 = (h1>>>1)+(h1>>>3)+(h2>>>2)+(h3>>>3).
  - The result saturates to [-32768, 32767] before it is registered.
- note_done:
  - When note_done=1 in IDLE, all phases clear to 0 on that cycle.
  - When note_done rises mid-sequence, the sequence still completes and the phases still advance. They are cleared on the next IDLE cycle.
- step_size and weight changes mid-sequence have no effect until the next accept.

Decomposition:
- Shared package harmonic_pkg holds:
  - the state encoding (IDLE, RD1, RD2, RD3, CAP3, OUT);
  - PHASE_W, ROM_AW and SAMPLE_W;
  - weight codes WEIGHT_H1, WEIGHT_H12 and WEIGHT_H123.
- One sub-module, sine_quadrant_fold: combinational; takes phase and rom_data and produces rom_addr and the signed sample. It is reused for all three lookups.

Test Plan:
1. Reset then first request. ROM model rom_data = addr*32. Set step_size=0x00100, weight=0 and issue a request. Required: sample_ready at cycle 5 with harmonic_out = 0. A second request gives harmonic_out = 32.
2. Quadrant walk. step_size=0x40000, weight=0, eight requests. Required harmonic_out sequence: 0, 32736, 0, -32736, repeating. Observed rom_addr for h1: 0, 1023, 0, 1023.
3. Weight 1. Ramp ROM, step_size=0x00100, request twice. Required: second output = 16+4+16+8 = 44.
4. Gating and busy. Pulse generate_next_sample during RD2, and also with play_enable=0, and also with note_done=1. Required: no extra sample_ready in any case, and harmonic_out unchanged. With note_done=1 in IDLE, the next accepted sample = 0.
5. Reset mid-sequence. Drive reset=0 during RD3. Required: sample_ready never pulses, all outputs return to 0 asynchronously, and the next request after release yields 0.
6. Saturation and weight 3. Constant ROM model rom_data=32767, with q=2 forced via step_size=0x80000 after one step. weight=3 must equal the weight=2 result, and harmonic_out must stay >= -32768, with no wrap.

Source files
------------

// File: rtl/harmonic_pkg.sv
// Shared definitions for the harmonic scheduler: sequencing states, widths,
// mix weight codes and the output saturation helper.
package harmonic_pkg;

    localparam int PHASE_W  = 20;
    localparam int ROM_AW   = 10;
    localparam int SAMPLE_W = 16;
    localparam int MIX_W    = 18;

    localparam logic [1:0] WEIGHT_H1   = 2'd0;
    localparam logic [1:0] WEIGHT_H12  = 2'd1;
    localparam logic [1:0] WEIGHT_H123 = 2'd2;

    localparam logic signed [MIX_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [MIX_W-1:0] SAT_MIN = -18'sd32768;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        RD3  = 3'd3,
        CAP3 = 3'd4,
        OUT  = 3'd5
    } state_t;

    function automatic logic signed [SAMPLE_W-1:0] saturate_mix(input logic signed [MIX_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[SAMPLE_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[SAMPLE_W-1:0];
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sine_quadrant_fold.sv
// Maps a full-cycle phase onto a quarter-wave ROM address and restores the
// sign of the looked-up magnitude for the phase's half-cycle.
module sine_quadrant_fold #(
    parameter int PHASE_W  = 20,
    parameter int ROM_AW   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic        [PHASE_W-1:0]  phase,
    input  logic        [SAMPLE_W-1:0] rom_data,
    output logic        [ROM_AW-1:0]   rom_addr,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic [1:0]        quadrant;
    logic [ROM_AW-1:0] angle;

    assign quadrant = phase[PHASE_W-1 -: 2];
    assign angle    = phase[PHASE_W-3 -: ROM_AW];

    // Odd quadrants run the quarter wave backwards; 1023-a is the bitwise inverse.
    assign rom_addr = quadrant[0] ? ~angle : angle;
    assign sample   = quadrant[1] ? -$signed(rom_data) : $signed(rom_data);

endmodule

// File: rtl/harmonic_scheduler.sv
// Time-shares one quarter-wave sine ROM between the 1x/2x/3x harmonic phase
// accumulators and mixes the three lookups into one saturated signed sample.
module harmonic_scheduler #(
    parameter int PHASE_W  = 20,
    parameter int ROM_AW   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic                       generate_next_sample,
    input  logic        [PHASE_W-1:0]  step_size,
    input  logic        [1:0]          weight,
    input  logic                       note_done,
    output logic        [ROM_AW-1:0]   rom_addr,
    input  logic        [SAMPLE_W-1:0] rom_data,
    output logic signed [SAMPLE_W-1:0] harmonic_out,
    output logic                       sample_ready,
    output logic                       busy
);
    import harmonic_pkg::*;

    state_t                     state_reg;
    logic        [PHASE_W-1:0]  phase_reg [3];
    logic        [PHASE_W-1:0]  step_reg  [3];
    logic        [1:0]          weight_reg;
    logic signed [SAMPLE_W-1:0] h1_reg;
    logic signed [SAMPLE_W-1:0] h2_reg;

    logic        [ROM_AW-1:0]   fold_addr   [3];
    logic signed [SAMPLE_W-1:0] fold_sample [3];

    logic                       accept;
    logic signed [MIX_W-1:0]    h1_ext;
    logic signed [MIX_W-1:0]    h2_ext;
    logic signed [MIX_W-1:0]    h3_ext;
    logic signed [MIX_W-1:0]    mix_next;

    // Phases only move in OUT or on an IDLE clear, so each fold's sign is
    // stable for the whole read sequence.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fold
            sine_quadrant_fold #(
                .PHASE_W  (PHASE_W),
                .ROM_AW   (ROM_AW),
                .SAMPLE_W (SAMPLE_W)
            ) u_fold (
                .phase    (phase_reg[gi]),
                .rom_data (rom_data),
                .rom_addr (fold_addr[gi]),
                .sample   (fold_sample[gi])
            );
        end
    endgenerate

    assign accept = (state_reg == IDLE) && generate_next_sample && play_enable && !note_done;

    assign h1_ext = {{(MIX_W-SAMPLE_W){h1_reg[SAMPLE_W-1]}}, h1_reg};
    assign h2_ext = {{(MIX_W-SAMPLE_W){h2_reg[SAMPLE_W-1]}}, h2_reg};
    assign h3_ext = {{(MIX_W-SAMPLE_W){fold_sample[2][SAMPLE_W-1]}}, fold_sample[2]};

    always_comb begin
        mix_next = h1_ext;
        case (weight_reg)
            WEIGHT_H1:  mix_next = h1_ext;
            WEIGHT_H12: mix_next = (h1_ext >>> 1) + (h1_ext >>> 3) + (h2_ext >>> 2) + (h2_ext >>> 3);
            default:    mix_next = (h1_ext >>> 1) + (h1_ext >>> 3) + (h2_ext >>> 2) + (h3_ext >>> 3);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            weight_reg   <= WEIGHT_H1;
            h1_reg       <= '0;
            h2_reg       <= '0;
            rom_addr     <= '0;
            harmonic_out <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                phase_reg[i] <= '0;
                step_reg[i]  <= '0;
            end
        end else begin
            sample_ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (note_done) begin
                        for (int i = 0; i < 3; i++) phase_reg[i] <= '0;
                    end
                    if (accept) begin
                        step_reg[0] <= step_size;
                        step_reg[1] <= step_size << 1;
                        step_reg[2] <= step_size + (step_size << 1);
                        weight_reg  <= weight;
                        rom_addr    <= fold_addr[0];
                        busy        <= 1'b1;
                        state_reg   <= RD1;
                    end
                end
                RD1: begin
                    rom_addr  <= fold_addr[1];
                    state_reg <= RD2;
                end
                RD2: begin
                    h1_reg    <= fold_sample[0];
                    rom_addr  <= fold_addr[2];
                    state_reg <= RD3;
                end
                RD3: begin
                    h2_reg    <= fold_sample[1];
                    state_reg <= CAP3;
                end
                CAP3: begin
                    // h3 is taken straight from the fold so the new sample and
                    // its strobe are already visible throughout OUT.
                    harmonic_out <= saturate_mix(mix_next);
                    sample_ready <= 1'b1;
                    state_reg    <= OUT;
                end
                OUT: begin
                    for (int i = 0; i < 3; i++) phase_reg[i] <= phase_reg[i] + step_reg[i];
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Directed bench for harmonic_scheduler: expected samples are queued when a
// request is issued and a monitor pops them on each sample_ready pulse.
module tb_harmonic_scheduler;

    logic               clk;
    logic               reset;
    logic               play_enable;
    logic               generate_next_sample;
    logic        [19:0] step_size;
    logic        [1:0]  weight;
    logic               note_done;
    logic        [9:0]  rom_addr;
    logic        [15:0] rom_data;
    logic signed [15:0] harmonic_out;
    logic               sample_ready;
    logic               busy;

    bit                 rom_const;
    int                 checks;
    int                 errors;
    logic signed [15:0] exp_q [$];
    logic signed [15:0] mon_exp;
    int                 out_w2;
    int                 out_w3;

    int quad_exp  [4] = '{0, 32736, 0, -32736};
    int quad_addr [4] = '{0, 1023, 0, 1023};

    harmonic_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .generate_next_sample (generate_next_sample),
        .step_size            (step_size),
        .weight               (weight),
        .note_done            (note_done),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .harmonic_out         (harmonic_out),
        .sample_ready         (sample_ready),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read ROM: ramp (addr*32) or constant full scale.
    always @(posedge clk)
        rom_data <= rom_const ? 16'd32767 : {1'b0, rom_addr, 5'b00000};

    always @(negedge clk) begin
        if (reset && sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample actual=%0d required=no sample_ready", harmonic_out);
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (harmonic_out !== mon_exp) begin
                    errors++;
                    $display("FAIL sample actual=%0d required=%0d", harmonic_out, mon_exp);
                end else begin
                    $display("sample out=%0d expected=%0d", harmonic_out, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accept edge, i.e. while the DUT is in RD1.
    task automatic request(input logic [19:0] step, input logic [1:0] w, input bit push, input int expv);
        step_size            = step;
        weight               = w;
        play_enable          = 1'b1;
        note_done            = 1'b0;
        generate_next_sample = 1'b1;
        if (push) exp_q.push_back(16'(expv));
        tick();
        generate_next_sample = 1'b0;
        check("accept_busy", int'(busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle within 20 cycles");
        end
    endtask

    task automatic clear_phases();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks               = 0;
        errors               = 0;
        reset                = 1'b0;
        play_enable          = 1'b0;
        generate_next_sample = 1'b0;
        step_size            = '0;
        weight               = '0;
        note_done            = 1'b0;
        rom_const            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", int'(harmonic_out), 0);
        check("reset_ready", int'(sample_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_addr", int'(rom_addr), 0);
        reset = 1'b1;
        tick();

        // Latency and first samples
        request(20'h00100, 2'd0, 1'b1, 0);
        repeat (3) tick();
        check("latency_c4_ready", int'(sample_ready), 0);
        tick();
        check("latency_c5_ready", int'(sample_ready), 1);
        check("latency_c5_busy", int'(busy), 1);
        wait_idle();
        request(20'h00100, 2'd0, 1'b1, 32);
        wait_idle();

        // Quadrant walk
        clear_phases();
        for (int i = 0; i < 8; i++) begin
            request(20'h40000, 2'd0, 1'b1, quad_exp[i % 4]);
            check("quad_addr", int'(rom_addr), quad_addr[i % 4]);
            wait_idle();
        end

        // Two-harmonic mix
        clear_phases();
        request(20'h00100, 2'd1, 1'b1, 0);
        wait_idle();
        request(20'h00100, 2'd1, 1'b1, 44);
        wait_idle();

        // Gating: request while busy, play_enable low, note_done high
        clear_phases();
        request(20'h00100, 2'd0, 1'b1, 0);
        tick();
        check("busy_rd2", int'(busy), 1);
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        wait_idle();
        request(20'h00100, 2'd0, 1'b1, 32);
        wait_idle();
        play_enable          = 1'b0;
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        play_enable          = 1'b1;
        repeat (7) tick();
        check("gate_play_busy", int'(busy), 0);
        check("gate_play_hold", int'(harmonic_out), 32);
        note_done            = 1'b1;
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        note_done            = 1'b0;
        repeat (7) tick();
        check("gate_done_busy", int'(busy), 0);
        check("gate_done_hold", int'(harmonic_out), 32);
        request(20'h00100, 2'd0, 1'b1, 0);
        wait_idle();

        // note_done rising mid-sequence: sample completes, clear happens in IDLE
        request(20'h00100, 2'd0, 1'b1, 32);
        tick();
        note_done = 1'b1;
        wait_idle();
        tick();
        note_done = 1'b0;
        request(20'h00100, 2'd0, 1'b1, 0);
        wait_idle();

        // Reset during RD3 aborts the sequence
        request(20'h00100, 2'd0, 1'b1, 32);
        wait_idle();
        request(20'h00100, 2'd0, 1'b0, 0);
        tick();
        tick();
        check("rd3_addr", int'(rom_addr), 6);
        reset = 1'b0;
        #1;
        check("abort_out", int'(harmonic_out), 0);
        check("abort_ready", int'(sample_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_addr", int'(rom_addr), 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        request(20'h00100, 2'd0, 1'b1, 0);
        wait_idle();

        // Full-scale ROM, three-harmonic mix, weight 2 vs 3
        rom_const = 1'b1;
        clear_phases();
        request(20'h80000, 2'd2, 1'b1, 32764);
        wait_idle();
        request(20'h80000, 2'd2, 1'b1, -16385);
        wait_idle();
        out_w2 = int'(harmonic_out);
        clear_phases();
        request(20'h80000, 2'd3, 1'b1, 32764);
        wait_idle();
        request(20'h80000, 2'd3, 1'b1, -16385);
        wait_idle();
        out_w3 = int'(harmonic_out);
        check("w3_equals_w2", out_w3, out_w2);

        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
